l1v_istek_hakemi: RTL and testbench
===================================

# l1v_istek_hakemi

Two-requester arbiter that shares the single L1 data-cache (l1v) request/response port between the memory stage's bus unit (requester 0) and a secondary requester (requester 1, e.g. the debug/atomic path). Grants the request channel with zero-latency pass-through, locks a grant until its handshake completes, and records the requester ID of every accepted read in an ID queue so in-order read responses are routed back to the issuer. Sits between the bus units and the l1v port.

## Interface
- ADRES_BIT, 32, request address width
- VERI_BIT, 32, data width; mask width is VERI_BIT/8
- KUYRUK_DERINLIK, 4, outstanding-read ID queue depth (power of two, >=2)

- clk_i  in  1  clock
- rstn_i  in  1  reset, asynchronous, active-low
- p0_istek_adres_i / p1_istek_adres_i  in  ADRES_BIT  request address
- p0_istek_gecerli_i / p1_istek_gecerli_i  in  1  request valid
- p0_istek_yaz_i / p1_istek_yaz_i  in  1  1 = write, 0 = read
- p0_istek_onbellekleme_i / p1_istek_onbellekleme_i  in  1  cacheable flag
- p0_istek_veri_i / p1_istek_veri_i  in  VERI_BIT  write data
- p0_istek_maske_i / p1_istek_maske_i  in  VERI_BIT/8  byte mask
- p0_istek_hazir_o / p1_istek_hazir_o  out  1  request accepted when valid & ready
- p0_veri_o / p1_veri_o  out  VERI_BIT  read data
- p0_veri_gecerli_o / p1_veri_gecerli_o  out  1  read data valid
- p0_veri_hazir_i / p1_veri_hazir_i  in  1  requester can take data
- l1v_istek_adres_o, l1v_istek_gecerli_o, l1v_istek_yaz_o, l1v_istek_onbellekleme_o, l1v_istek_veri_o, l1v_istek_maske_o  out  granted request fields
- l1v_istek_hazir_i  in  1  l1v accepts request
- l1v_veri_i  in  VERI_BIT  response data; l1v_veri_gecerli_i  in  1; l1v_veri_hazir_o  out  1
- hata_o  out  1  sticky: response arrived with empty ID queue

## Operation
- Eligible requester: valid high and, if read, ID queue not full. Writes never depend on queue state.
- Selection (no lock): one eligible → it; both → priority rule (see Configuration). Granted requester's fields muxed to l1v_*; l1v_istek_gecerli_o = eligible grant exists; granted pN_istek_hazir_o = l1v_istek_hazir_i; other hazir_o = 0.
- Lock: state BOS/KILITLI. BOS → KILITLI when a grant is driven and l1v_istek_hazir_i = 0; kilit_id register stores grantee. In KILITLI only kilit_id may be granted; return to BOS on its handshake. Requesters hold valid and fields stable until accepted.
- Accepted read (handshake with yaz=0): push grantee ID into queue. Writes push nothing and produce no response.
- Response: head ID selects destination; pH_veri_o = l1v_veri_i, pH_veri_gecerli_o = l1v_veri_gecerli_i, l1v_veri_hazir_o = pH_veri_hazir_i; other requester sees gecerli 0. Pop on l1v_veri_gecerli_i & l1v_veri_hazir_o.
- Queue empty and l1v_veri_gecerli_i = 1: l1v_veri_hazir_o = 1 (beat dropped), hata_o set until reset.
- Full queue: read eligibility uses registered count only; a pop in the same cycle does not unblock a read until next cycle. Push and pop in same cycle keep count unchanged.
- Pointers wrap modulo KUYRUK_DERINLIK; count width log2(depth)+1.

## Timing
- Request path fully combinational: zero added latency, one request per cycle max.
- Response path combinational from queue head; zero latency.
- Lock, queue, pointers, hata_o, round-robin pointer update on clk_i rising edge.
- Reset (asynchronous assert, synchronous-safe release): queue empty, state BOS, round-robin favours p0, hata_o = 0. Then all gecerli/hazir outputs 0 until inputs assert; data outputs follow muxes (0 with idle inputs). Reset mid-transaction discards outstanding IDs; late responses after reset set hata_o.

## Configuration
- HAKEM_DONEN_ONCELIK_EN defined: round-robin; after each accepted request the other requester gets priority on next contention.
- Undefined: fixed priority, p0 always wins contention; p1 only granted when p0 ineligible (lock still honoured).

## Test plan
- p0 read 0x100 and p1 read 0x200 same cycle, l1v ready → p0 granted first (both configs), p1 next cycle; responses 0xAAAA then 0xBBBB reach p0 then p1.
- p1 granted with l1v_istek_hazir_i low 3 cycles, p0 asserts meanwhile → l1v fields stay p1's until accept, then p0.
- Four reads accepted, no responses (depth 4) → fifth read hazir_o = 0; p0 write 0x300 still accepted; one response pops, read accepted next cycle.
- Response with queue empty → l1v_veri_hazir_o = 1, hata_o rises and stays 1 until rstn_i low.
- Continuous contention 8 requests each, macro defined → grants alternate p0,p1,...; undefined → all p0 first.
- Assert rstn_i mid-lock with 2 reads outstanding → outputs idle immediately, queue empty after release.

Source files
------------

// File: rtl/l1v_istek_hakemi_if.sv
// Request/response bundle between a bus unit and the l1v data-cache port.
// The arbiter takes two bundles as slave (requesters) and drives one as master (l1v side).
interface l1v_istek_hakemi_if #(
    parameter int unsigned ADRES_BIT = 32,
    parameter int unsigned VERI_BIT  = 32
);
    logic [ADRES_BIT-1:0]  istek_adres;
    logic                  istek_gecerli;
    logic                  istek_yaz;
    logic                  istek_onbellekleme;
    logic [VERI_BIT-1:0]   istek_veri;
    logic [VERI_BIT/8-1:0] istek_maske;
    logic                  istek_hazir;
    logic [VERI_BIT-1:0]   veri;
    logic                  veri_gecerli;
    logic                  veri_hazir;

    modport master (
        output istek_adres, istek_gecerli, istek_yaz, istek_onbellekleme, istek_veri, istek_maske,
        input  istek_hazir,
        input  veri, veri_gecerli,
        output veri_hazir
    );

    modport slave (
        input  istek_adres, istek_gecerli, istek_yaz, istek_onbellekleme, istek_veri, istek_maske,
        output istek_hazir,
        output veri, veri_gecerli,
        input  veri_hazir
    );
endinterface

// File: rtl/l1v_istek_hakemi.sv
// Two-requester arbiter for the l1v request/response port with in-order read ID routing.
// Define HAKEM_DONEN_ONCELIK_EN for round-robin contention; default is fixed p0 priority.
module l1v_istek_hakemi #(
    parameter int unsigned ADRES_BIT       = 32,
    parameter int unsigned VERI_BIT        = 32,
    parameter int unsigned KUYRUK_DERINLIK = 4
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    l1v_istek_hakemi_if.slave   p0,
    l1v_istek_hakemi_if.slave   p1,
    l1v_istek_hakemi_if.master  l1v,
    output logic                hata_o
);
    localparam int unsigned IS_BIT  = $clog2(KUYRUK_DERINLIK);
    localparam int unsigned SAY_BIT = IS_BIT + 1;

    typedef enum logic {BOS, KILITLI} durum_e;

    durum_e               durum_q, durum_d;
    logic                 kilit_id_q, kilit_id_d;
    logic                 secim, secim_gecerli;
    logic                 uygun0, uygun1, dolu, bos;
    logic                 kabul, itme, cekme, bas_id;
    logic [IS_BIT-1:0]    yaz_ptr_q, oku_ptr_q;
    logic [SAY_BIT-1:0]   sayac_q;
    logic                 kuyruk_q [KUYRUK_DERINLIK];
    logic                 hata_q;
    logic [ADRES_BIT-1:0] sec_adres;
    logic [VERI_BIT-1:0]  sec_veri;
`ifdef HAKEM_DONEN_ONCELIK_EN
    logic                 oncelik_q;
`endif

    // Reads need a free ID slot; the registered count alone decides fullness.
    assign dolu   = (sayac_q == SAY_BIT'(KUYRUK_DERINLIK));
    assign bos    = (sayac_q == '0);
    assign uygun0 = p0.istek_gecerli & (p0.istek_yaz | ~dolu);
    assign uygun1 = p1.istek_gecerli & (p1.istek_yaz | ~dolu);

    // Grant selection and lock next-state.
    always_comb begin
        durum_d       = durum_q;
        kilit_id_d    = kilit_id_q;
        secim         = 1'b0;
        secim_gecerli = 1'b0;
        case (durum_q)
            BOS: begin
                secim_gecerli = uygun0 | uygun1;
`ifdef HAKEM_DONEN_ONCELIK_EN
                secim = uygun1 & (~uygun0 | oncelik_q);
`else
                secim = uygun1 & ~uygun0;
`endif
                if (secim_gecerli && !l1v.istek_hazir) begin
                    durum_d    = KILITLI;
                    kilit_id_d = secim;
                end
            end
            KILITLI: begin
                secim         = kilit_id_q;
                secim_gecerli = kilit_id_q ? uygun1 : uygun0;
                if (secim_gecerli && l1v.istek_hazir) durum_d = BOS;
            end
            default: durum_d = BOS;
        endcase
    end

    // Zero-latency request mux.
    assign sec_adres                = secim ? p1.istek_adres : p0.istek_adres;
    assign sec_veri                 = secim ? p1.istek_veri  : p0.istek_veri;
    assign l1v.istek_adres          = sec_adres;
    assign l1v.istek_veri           = sec_veri;
    assign l1v.istek_yaz            = secim ? p1.istek_yaz : p0.istek_yaz;
    assign l1v.istek_onbellekleme   = secim ? p1.istek_onbellekleme : p0.istek_onbellekleme;
    assign l1v.istek_maske          = secim ? p1.istek_maske : p0.istek_maske;
    assign l1v.istek_gecerli        = secim_gecerli;
    assign p0.istek_hazir           = secim_gecerli & ~secim & l1v.istek_hazir;
    assign p1.istek_hazir           = secim_gecerli &  secim & l1v.istek_hazir;

    assign kabul = secim_gecerli & l1v.istek_hazir;
    assign itme  = kabul & ~l1v.istek_yaz;

    // Response routing from the ID queue head; beats with no owner are drained.
    assign bas_id          = kuyruk_q[oku_ptr_q];
    assign p0.veri         = (!bos && !bas_id) ? l1v.veri : '0;
    assign p1.veri         = (!bos &&  bas_id) ? l1v.veri : '0;
    assign p0.veri_gecerli = ~bos & ~bas_id & l1v.veri_gecerli;
    assign p1.veri_gecerli = ~bos &  bas_id & l1v.veri_gecerli;
    assign l1v.veri_hazir  = bos ? l1v.veri_gecerli : (bas_id ? p1.veri_hazir : p0.veri_hazir);
    assign cekme           = ~bos & l1v.veri_gecerli & l1v.veri_hazir;
    assign hata_o          = hata_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            durum_q    <= BOS;
            kilit_id_q <= 1'b0;
        end else begin
            durum_q    <= durum_d;
            kilit_id_q <= kilit_id_d;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            yaz_ptr_q <= '0;
            oku_ptr_q <= '0;
            sayac_q   <= '0;
            hata_q    <= 1'b0;
            for (int i = 0; i < int'(KUYRUK_DERINLIK); i++) kuyruk_q[i] <= 1'b0;
        end else begin
            if (itme) begin
                kuyruk_q[yaz_ptr_q] <= secim;
                yaz_ptr_q           <= yaz_ptr_q + IS_BIT'(1);
            end
            if (cekme) oku_ptr_q <= oku_ptr_q + IS_BIT'(1);
            case ({itme, cekme})
                2'b10:   sayac_q <= sayac_q + SAY_BIT'(1);
                2'b01:   sayac_q <= sayac_q - SAY_BIT'(1);
                default: sayac_q <= sayac_q;
            endcase
            if (bos && l1v.veri_gecerli) hata_q <= 1'b1;
        end
    end

`ifdef HAKEM_DONEN_ONCELIK_EN
    // After each accepted request the other requester wins the next contention.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i)    oncelik_q <= 1'b0;
        else if (kabul) oncelik_q <= ~secim;
    end
`endif
endmodule

// File: tb/tb_l1v_istek_hakemi.sv
// Scoreboard bench for l1v_istek_hakemi: expected grants and responses are queued at stimulus time.
module tb_l1v_istek_hakemi;
    typedef struct packed { logic yaz; logic [31:0] adres; } istek_t;
    typedef struct packed { logic id;  logic [31:0] deger; } bek_t;

    logic clk = 1'b0;
    logic rstn = 1'b1;
    logic hata;
    int   n_pass = 0;
    int   n_total = 0;
    istek_t q0[$], q1[$];
    bek_t   gq[$], rq[$];

    always #5 clk = ~clk;

    l1v_istek_hakemi_if #(.ADRES_BIT(32), .VERI_BIT(32)) p0_if ();
    l1v_istek_hakemi_if #(.ADRES_BIT(32), .VERI_BIT(32)) p1_if ();
    l1v_istek_hakemi_if #(.ADRES_BIT(32), .VERI_BIT(32)) l1v_if ();

    l1v_istek_hakemi #(.ADRES_BIT(32), .VERI_BIT(32), .KUYRUK_DERINLIK(4)) dut (
        .clk_i(clk), .rstn_i(rstn), .p0(p0_if), .p1(p1_if), .l1v(l1v_if), .hata_o(hata)
    );

    function automatic istek_t mk_i(input logic yaz, input logic [31:0] a);
        istek_t r; r.yaz = yaz; r.adres = a; return r;
    endfunction
    function automatic bek_t mk_b(input logic id, input logic [31:0] d);
        bek_t r; r.id = id; r.deger = d; return r;
    endfunction

    task automatic tik();
        @(posedge clk); #2;
    endtask

    // Presents queued requests, holding each until its handshake.
    task automatic driver();
        bit a0, a1;
        forever begin
            @(negedge clk);
            a0 = p0_if.istek_gecerli && p0_if.istek_hazir;
            a1 = p1_if.istek_gecerli && p1_if.istek_hazir;
            @(posedge clk or negedge rstn);
            if (rstn) begin
                #1;
                if (a0 && q0.size() != 0) void'(q0.pop_front());
                if (a1 && q1.size() != 0) void'(q1.pop_front());
            end
            p0_if.istek_gecerli      = (q0.size() != 0);
            p0_if.istek_yaz          = (q0.size() != 0) ? q0[0].yaz : 1'b0;
            p0_if.istek_adres        = (q0.size() != 0) ? q0[0].adres : 32'h0;
            p0_if.istek_veri         = (q0.size() != 0) ? (q0[0].adres ^ 32'hA5A5_0000) : 32'h0;
            p0_if.istek_maske        = (q0.size() != 0) ? 4'hF : 4'h0;
            p0_if.istek_onbellekleme = (q0.size() != 0);
            p1_if.istek_gecerli      = (q1.size() != 0);
            p1_if.istek_yaz          = (q1.size() != 0) ? q1[0].yaz : 1'b0;
            p1_if.istek_adres        = (q1.size() != 0) ? q1[0].adres : 32'h0;
            p1_if.istek_veri         = (q1.size() != 0) ? (q1[0].adres ^ 32'h5A5A_0000) : 32'h0;
            p1_if.istek_maske        = (q1.size() != 0) ? 4'h3 : 4'h0;
            p1_if.istek_onbellekleme = 1'b0;
        end
    endtask

    // Pops the scoreboards whenever the DUT completes a request or response handshake.
    task automatic monitor();
        bek_t e;
        forever begin
            @(negedge clk);
            if (rstn && l1v_if.istek_gecerli && l1v_if.istek_hazir) begin
                n_total++;
                if (gq.size() == 0)
                    $display("FAIL grant_unexpected got hazir=%b%b adres=%h want no grant",
                             p0_if.istek_hazir, p1_if.istek_hazir, l1v_if.istek_adres);
                else begin
                    e = gq.pop_front();
                    if ({p0_if.istek_hazir, p1_if.istek_hazir, l1v_if.istek_adres} !== {~e.id, e.id, e.deger})
                        $display("FAIL grant_order got hazir=%b%b adres=%h want id=%0d adres=%h",
                                 p0_if.istek_hazir, p1_if.istek_hazir, l1v_if.istek_adres, e.id, e.deger);
                    else n_pass++;
                end
            end
            if (rstn && l1v_if.veri_gecerli && rq.size() != 0) begin
                e = rq.pop_front();
                n_total++;
                if ({l1v_if.veri_hazir, p0_if.veri_gecerli, p1_if.veri_gecerli, (e.id ? p1_if.veri : p0_if.veri)}
                    !== {1'b1, ~e.id, e.id, e.deger})
                    $display("FAIL response_route got hazir=%b gecerli=%b%b veri0=%h veri1=%h want id=%0d veri=%h",
                             l1v_if.veri_hazir, p0_if.veri_gecerli, p1_if.veri_gecerli, p0_if.veri, p1_if.veri,
                             e.id, e.deger);
                else n_pass++;
            end
        end
    endtask

    task automatic bekle_gq(output bit ok);
        for (int i = 0; i < 80; i++) begin
            if (gq.size() == 0) break;
            @(negedge clk);
        end
        ok = (gq.size() == 0);
    endtask

    task automatic yanit(input logic id, input logic [31:0] v);
        l1v_if.veri_gecerli = 1'b1;
        l1v_if.veri         = v;
        rq.push_back(mk_b(id, v));
        tik();
        l1v_if.veri_gecerli = 1'b0;
        l1v_if.veri         = 32'h0;
    endtask

    task automatic test_reset();
        #1 rstn = 1'b0;
        tik();
        @(negedge clk);
        n_total++;
        if (hata !== 1'b0) $display("FAIL reset_hata got=%b want=0", hata); else n_pass++;
        tik();
        rstn = 1'b1;
        tik();
        @(negedge clk);
        n_total++;
        if ({l1v_if.istek_gecerli, p0_if.istek_hazir, p1_if.istek_hazir} !== 3'b000)
            $display("FAIL reset_req_handshake got=%b want=000",
                     {l1v_if.istek_gecerli, p0_if.istek_hazir, p1_if.istek_hazir});
        else n_pass++;
        n_total++;
        if ({l1v_if.veri_hazir, p0_if.veri_gecerli, p1_if.veri_gecerli, hata} !== 4'b0000)
            $display("FAIL reset_resp_handshake got=%b want=0000",
                     {l1v_if.veri_hazir, p0_if.veri_gecerli, p1_if.veri_gecerli, hata});
        else n_pass++;
        n_total++;
        if ({l1v_if.istek_adres, l1v_if.istek_veri, p0_if.veri} !== 96'h0)
            $display("FAIL reset_data got adres=%h veri=%h p0_veri=%h want 0",
                     l1v_if.istek_adres, l1v_if.istek_veri, p0_if.veri);
        else n_pass++;
        tik();
    endtask

    task automatic test_contention();
        bit ok;
        l1v_if.istek_hazir = 1'b1;
        q0.push_back(mk_i(1'b0, 32'h100));
        q1.push_back(mk_i(1'b0, 32'h200));
        gq.push_back(mk_b(1'b0, 32'h100));
        gq.push_back(mk_b(1'b1, 32'h200));
        tik();
        @(negedge clk);
        n_total++;
        if ({p0_if.istek_gecerli, p1_if.istek_gecerli, p0_if.istek_hazir, p1_if.istek_hazir} !== 4'b1110)
            $display("FAIL contention_first got=%b want=1110",
                     {p0_if.istek_gecerli, p1_if.istek_gecerli, p0_if.istek_hazir, p1_if.istek_hazir});
        else n_pass++;
        bekle_gq(ok);
        n_total++;
        if (ok !== 1'b1) $display("FAIL contention_timeout pending=%0d want=0", gq.size()); else n_pass++;
        tik();
        yanit(1'b0, 32'h0000_AAAA);
        yanit(1'b1, 32'h0000_BBBB);
    endtask

    task automatic test_hold();
        bit ok;
        l1v_if.istek_hazir = 1'b0;
        q1.push_back(mk_i(1'b0, 32'h240));
        gq.push_back(mk_b(1'b1, 32'h240));
        gq.push_back(mk_b(1'b0, 32'h140));
        tik();
        q0.push_back(mk_i(1'b0, 32'h140));
        tik();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_total++;
            if ({p0_if.istek_gecerli, l1v_if.istek_gecerli, l1v_if.istek_adres, p0_if.istek_hazir} !== {2'b11, 32'h240, 1'b0})
                $display("FAIL hold_lock cyc=%0d got p0v=%b gecerli=%b adres=%h p0_hazir=%b want 1 1 240 0", i,
                         p0_if.istek_gecerli, l1v_if.istek_gecerli, l1v_if.istek_adres, p0_if.istek_hazir);
            else n_pass++;
            tik();
        end
        l1v_if.istek_hazir = 1'b1;
        bekle_gq(ok);
        n_total++;
        if (ok !== 1'b1) $display("FAIL hold_timeout pending=%0d want=0", gq.size()); else n_pass++;
        tik();
        yanit(1'b1, 32'h0000_2222);
        yanit(1'b0, 32'h0000_1111);
    endtask

    task automatic test_full();
        bit ok;
        l1v_if.istek_hazir = 1'b1;
        for (int i = 0; i < 4; i++) begin
            q0.push_back(mk_i(1'b0, 32'h400 + 32'(4 * i)));
            gq.push_back(mk_b(1'b0, 32'h400 + 32'(4 * i)));
        end
        bekle_gq(ok);
        n_total++;
        if (ok !== 1'b1) $display("FAIL full_fill_timeout pending=%0d want=0", gq.size()); else n_pass++;
        tik();
        q1.push_back(mk_i(1'b0, 32'h500));
        tik();
        tik();
        @(negedge clk);
        n_total++;
        if ({p1_if.istek_gecerli, p1_if.istek_hazir, l1v_if.istek_gecerli} !== 3'b100)
            $display("FAIL full_read_blocked got=%b want=100",
                     {p1_if.istek_gecerli, p1_if.istek_hazir, l1v_if.istek_gecerli});
        else n_pass++;
        q0.push_back(mk_i(1'b1, 32'h300));
        gq.push_back(mk_b(1'b0, 32'h300));
        bekle_gq(ok);
        n_total++;
        if (ok !== 1'b1) $display("FAIL full_write_timeout pending=%0d want=0", gq.size()); else n_pass++;
        gq.push_back(mk_b(1'b1, 32'h500));
        tik();
        l1v_if.veri_gecerli = 1'b1;
        l1v_if.veri         = 32'h0000_4444;
        rq.push_back(mk_b(1'b0, 32'h0000_4444));
        @(negedge clk);
        n_total++;
        if (p1_if.istek_hazir !== 1'b0) $display("FAIL full_pop_same_cycle got=%b want=0", p1_if.istek_hazir);
        else n_pass++;
        tik();
        l1v_if.veri_gecerli = 1'b0;
        l1v_if.veri         = 32'h0;
        @(negedge clk);
        n_total++;
        if (p1_if.istek_hazir !== 1'b1) $display("FAIL full_unblock got=%b want=1", p1_if.istek_hazir);
        else n_pass++;
        bekle_gq(ok);
        n_total++;
        if (ok !== 1'b1) $display("FAIL full_read_timeout pending=%0d want=0", gq.size()); else n_pass++;
        tik();
        for (int i = 0; i < 3; i++) yanit(1'b0, 32'h0000_4445 + 32'(i));
        yanit(1'b1, 32'h0000_5555);
    endtask

    task automatic test_hata();
        l1v_if.veri_gecerli = 1'b1;
        l1v_if.veri         = 32'h0000_DEAD;
        @(negedge clk);
        n_total++;
        if ({l1v_if.veri_hazir, p0_if.veri_gecerli, p1_if.veri_gecerli, hata} !== 4'b1000)
            $display("FAIL drop_beat got=%b want=1000",
                     {l1v_if.veri_hazir, p0_if.veri_gecerli, p1_if.veri_gecerli, hata});
        else n_pass++;
        tik();
        l1v_if.veri_gecerli = 1'b0;
        l1v_if.veri         = 32'h0;
        @(negedge clk);
        n_total++;
        if (hata !== 1'b1) $display("FAIL hata_set got=%b want=1", hata); else n_pass++;
        repeat (5) tik();
        @(negedge clk);
        n_total++;
        if (hata !== 1'b1) $display("FAIL hata_sticky got=%b want=1", hata); else n_pass++;
        tik();
    endtask

    task automatic test_reset_mid();
        bit ok;
        l1v_if.istek_hazir = 1'b1;
        q0.push_back(mk_i(1'b0, 32'h800));
        q0.push_back(mk_i(1'b0, 32'h804));
        gq.push_back(mk_b(1'b0, 32'h800));
        gq.push_back(mk_b(1'b0, 32'h804));
        bekle_gq(ok);
        n_total++;
        if (ok !== 1'b1) $display("FAIL rmid_timeout pending=%0d want=0", gq.size()); else n_pass++;
        tik();
        l1v_if.istek_hazir = 1'b0;
        q1.push_back(mk_i(1'b0, 32'h900));
        tik();
        tik();
        @(negedge clk);
        n_total++;
        if ({l1v_if.istek_gecerli, l1v_if.istek_adres} !== {1'b1, 32'h900})
            $display("FAIL rmid_lock got gecerli=%b adres=%h want 1 900", l1v_if.istek_gecerli, l1v_if.istek_adres);
        else n_pass++;
        #2;
        q0.delete();
        q1.delete();
        rstn = 1'b0;
        #1;
        n_total++;
        if ({l1v_if.istek_gecerli, p1_if.istek_hazir, l1v_if.veri_hazir, hata} !== 4'b0000)
            $display("FAIL rmid_idle got=%b want=0000",
                     {l1v_if.istek_gecerli, p1_if.istek_hazir, l1v_if.veri_hazir, hata});
        else n_pass++;
        tik();
        tik();
        rstn = 1'b1;
        tik();
        l1v_if.veri_gecerli = 1'b1;
        l1v_if.veri         = 32'h0000_7777;
        @(negedge clk);
        n_total++;
        if ({l1v_if.veri_hazir, p0_if.veri_gecerli, p1_if.veri_gecerli} !== 3'b100)
            $display("FAIL rmid_queue_empty got=%b want=100",
                     {l1v_if.veri_hazir, p0_if.veri_gecerli, p1_if.veri_gecerli});
        else n_pass++;
        tik();
        l1v_if.veri_gecerli = 1'b0;
        l1v_if.veri         = 32'h0;
        @(negedge clk);
        n_total++;
        if (hata !== 1'b1) $display("FAIL rmid_late_hata got=%b want=1", hata); else n_pass++;
        tik();
    endtask

    task automatic test_back_to_back();
        bit ok;
        l1v_if.istek_hazir = 1'b1;
        for (int i = 0; i < 8; i++) begin
            q0.push_back(mk_i(1'b1, 32'h600 + 32'(4 * i)));
            q1.push_back(mk_i(1'b1, 32'h700 + 32'(4 * i)));
`ifdef HAKEM_DONEN_ONCELIK_EN
            gq.push_back(mk_b(1'b0, 32'h600 + 32'(4 * i)));
            gq.push_back(mk_b(1'b1, 32'h700 + 32'(4 * i)));
`endif
        end
`ifndef HAKEM_DONEN_ONCELIK_EN
        for (int i = 0; i < 8; i++) gq.push_back(mk_b(1'b0, 32'h600 + 32'(4 * i)));
        for (int i = 0; i < 8; i++) gq.push_back(mk_b(1'b1, 32'h700 + 32'(4 * i)));
`endif
        bekle_gq(ok);
        n_total++;
        if (ok !== 1'b1) $display("FAIL b2b_timeout pending=%0d want=0", gq.size()); else n_pass++;
        tik();
        tik();
    endtask

    initial begin
        p0_if.veri_hazir      = 1'b1;
        p1_if.veri_hazir      = 1'b1;
        p0_if.istek_gecerli   = 1'b0;
        p1_if.istek_gecerli   = 1'b0;
        l1v_if.istek_hazir    = 1'b0;
        l1v_if.veri_gecerli   = 1'b0;
        l1v_if.veri           = 32'h0;
        fork
            driver();
            monitor();
        join_none
        test_reset();
        test_contention();
        test_hold();
        test_full();
        test_hata();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
